// File: rtl/calc.sv
// Four-digit BCD calculator with debounced-edge button inputs and a
// multiplexed active-low seven-segment display.
module calc #(
    parameter int unsigned REFRESH_W = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    input  logic       E,
    input  logic       gen,
    output logic [6:0] LEDs,
    output logic [3:0] active,
    output logic       point
);

    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

    logic [4:0] pins;
    logic [4:0] s1, s2, prev;
    logic [1:0] flush;
    logic [4:0] ev;

    logic [3:0] da, db, dc, dd;
    op_t        op;
    logic [13:0] r;
    logic        neg, err, show;

    logic [REFRESH_W-1:0] cnt;
    logic [1:0]           sel;

    logic [6:0]  x, y;
    logic [13:0] res;
    logic        res_neg, res_err;
    logic [3:0]  digit;

    assign pins = {gen, D, C, B, A};

    // prev is held high until the synchronizers have flushed, so a button
    // already down when reset releases never looks like a fresh press
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            prev  <= '1;
            flush <= '0;
        end else begin
            s1 <= pins;
            s2 <= s1;
            if (flush != 2'd2) begin
                flush <= flush + 2'd1;
                prev  <= '1;
            end else begin
                prev <= s2;
            end
        end
    end

    assign ev = s2 & ~prev;

    function automatic logic [3:0] inc_bcd(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    assign x = {3'b000, da} * 7'd10 + {3'b000, db};
    assign y = {3'b000, dc} * 7'd10 + {3'b000, dd};

    always_comb begin
        res     = '0;
        res_neg = 1'b0;
        res_err = 1'b0;
        case (op)
            OP_ADD: res = {7'b0, x} + {7'b0, y};
            OP_SUB: begin
                if (x >= y) begin
                    res = {7'b0, x - y};
                end else begin
                    res     = {7'b0, y - x};
                    res_neg = 1'b1;
                end
            end
            OP_MUL: res = {7'b0, x} * {7'b0, y};
            OP_DIV: begin
                if (y == 7'd0) res_err = 1'b1;
                else           res     = {7'b0, x / y};
            end
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            da   <= '0;
            db   <= '0;
            dc   <= '0;
            dd   <= '0;
            op   <= OP_ADD;
            r    <= '0;
            neg  <= 1'b0;
            err  <= 1'b0;
            show <= 1'b0;
        end else begin
            if (!E) begin
                if (ev[0]) da <= inc_bcd(da);
                if (ev[1]) db <= inc_bcd(db);
                if (ev[2]) dc <= inc_bcd(dc);
                if (ev[3]) dd <= inc_bcd(dd);
                if (|ev[3:0]) show <= 1'b0;
            end else begin
                if      (ev[3]) op <= OP_DIV;
                else if (ev[2]) op <= OP_MUL;
                else if (ev[1]) op <= OP_SUB;
                else if (ev[0]) op <= OP_ADD;
            end
            if (ev[4]) begin
                r    <= res;
                neg  <= res_neg;
                err  <= res_err;
                show <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt + REFRESH_W'(1);
    end

    assign sel    = cnt[REFRESH_W-1 -: 2];
    assign active = ~(4'b0001 << sel);

    always_comb begin
        digit = '0;
        if (show) begin
            case (sel)
                2'd0: digit = 4'(r % 14'd10);
                2'd1: digit = 4'((r / 14'd10) % 14'd10);
                2'd2: digit = 4'((r / 14'd100) % 14'd10);
                2'd3: digit = 4'(r / 14'd1000);
                default: digit = '0;
            endcase
        end else begin
            case (sel)
                2'd0: digit = dd;
                2'd1: digit = dc;
                2'd2: digit = db;
                2'd3: digit = da;
                default: digit = '0;
            endcase
        end
    end

    always_comb begin
        LEDs = 7'b1111111;
        case (digit)
            4'd0: LEDs = 7'b1000000;
            4'd1: LEDs = 7'b1111001;
            4'd2: LEDs = 7'b0100100;
            4'd3: LEDs = 7'b0110000;
            4'd4: LEDs = 7'b0011001;
            4'd5: LEDs = 7'b0010010;
            4'd6: LEDs = 7'b0000010;
            4'd7: LEDs = 7'b1111000;
            4'd8: LEDs = 7'b0000000;
            4'd9: LEDs = 7'b0010000;
            default: LEDs = 7'b1111111;
        endcase
    end

    assign point = ~(show && (err || (neg && sel == 2'd3)));

endmodule

// File: tb/tb_calc.sv
// Directed and randomized bench for calc against an arithmetic model of
// the calculator's operands, operator and displayed result.
module tb_calc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0, E = 1'b0, gen = 1'b0;
    logic [6:0] LEDs;
    logic [3:0] active;
    logic       point;

    int nchecks = 0;
    int nerr    = 0;

    logic [6:0] segtab [10];

    int md [4];
    int mop, mr;
    bit mneg, merr, mshow;

    calc #(.REFRESH_W(4)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D), .E(E), .gen(gen),
        .LEDs(LEDs), .active(active), .point(point)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pos_of(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int exp_digit(input int p);
        int d;
        if (mshow) begin
            d = mr;
            for (int i = 0; i < p; i++) d = d / 10;
            return d % 10;
        end
        return md[3-p];
    endfunction

    function automatic bit exp_point(input int p);
        return !(mshow && (merr || (mneg && p == 3)));
    endfunction

    task automatic model_apply(input logic [4:0] m);
        int x, y;
        if (m[4]) begin
            x = 10*md[0] + md[1];
            y = 10*md[2] + md[3];
            mneg = 0;
            merr = 0;
            case (mop)
                0: mr = x + y;
                1: if (x >= y) mr = x - y; else begin mr = y - x; mneg = 1; end
                2: mr = x * y;
                default: if (y == 0) begin mr = 0; merr = 1; end else mr = x / y;
            endcase
            mshow = 1;
        end else if (!E) begin
            for (int i = 0; i < 4; i++) if (m[i]) md[i] = (md[i] + 1) % 10;
            if (m[3:0] != 0) mshow = 0;
        end else begin
            for (int i = 0; i < 4; i++) if (m[i]) mop = i;
        end
    endtask

    task automatic check_now(input string tag);
        int p;
        p = pos_of(active);
        chk({tag, "_onehot"}, 32'(p >= 0), 32'd1);
        if (p >= 0) begin
            chk({tag, "_leds"}, 32'(LEDs), 32'(segtab[exp_digit(p)]));
            chk({tag, "_point"}, 32'(point), 32'(exp_point(p)));
        end
    endtask

    task automatic check_disp(input string tag);
        int p, prev;
        logic [3:0] seen;
        prev = -1;
        seen = '0;
        repeat (16) begin
            @(negedge clk);
            p = pos_of(active);
            chk({tag, "_onehot"}, 32'(p >= 0), 32'd1);
            if (p >= 0) begin
                if (prev >= 0)
                    chk({tag, "_order"}, 32'((p == prev) || (p == (prev + 1) % 4)), 32'd1);
                chk({tag, "_leds"}, 32'(LEDs), 32'(segtab[exp_digit(p)]));
                chk({tag, "_point"}, 32'(point), 32'(exp_point(p)));
                seen[p] = 1'b1;
                prev = p;
            end
        end
        chk({tag, "_allpos"}, 32'(seen), 32'hF);
    endtask

    task automatic set_pins(input logic [4:0] m);
        {gen, D, C, B, A} = m;
    endtask

    task automatic press(input logic [4:0] m);
        int h;
        h = $urandom_range(1, 3);
        model_apply(m);
        @(negedge clk);
        set_pins(m);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (i == h - 1) set_pins('0);
            if (m[4] && i == 3) check_now("gen_latency");
        end
    endtask

    task automatic set_e(input logic v);
        @(negedge clk);
        E = v;
    endtask

    task automatic set_digits(input int a, input int b, input int c, input int d);
        int t [4];
        int n;
        t = '{a, b, c, d};
        set_e(1'b0);
        for (int i = 0; i < 4; i++) begin
            n = (t[i] - md[i] + 10) % 10;
            for (int j = 0; j < n; j++) press(5'(1 << i));
        end
    endtask

    initial begin
        segtab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                   7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        md = '{0, 0, 0, 0};
        mop = 0; mr = 0; mneg = 0; merr = 0; mshow = 0;

        // reset with A held across release: must not register as a press
        A = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_active", 32'(active), 32'b1110);
        chk("rst_leds", 32'(LEDs), 32'b1000000);
        chk("rst_point", 32'(point), 32'd1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        A = 1'b0;
        repeat (4) @(posedge clk);
        check_disp("reset");

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 9; j++) press(5'(1 << i));
        check_disp("d9999");
        press(5'b00001);
        check_disp("d0999");

        set_digits(9, 9, 9, 9);
        set_e(1'b1);
        press(5'b00001);
        press(5'b00010);
        press(5'b00100);
        press(5'b01000);
        press(5'b10000);
        check_disp("div9999");
        press(5'b00100);
        press(5'b10000);
        check_disp("mul9999");

        set_digits(1, 2, 3, 4);
        set_e(1'b1);
        press(5'b00010);
        press(5'b10000);
        check_disp("sub_neg");
        set_digits(3, 4, 1, 2);
        check_disp("operands3412");
        press(5'b10000);
        check_disp("sub_pos");

        set_digits(4, 7, 0, 5);
        set_e(1'b1);
        press(5'b01000);
        press(5'b10000);
        check_disp("div4705");
        set_digits(4, 7, 0, 0);
        press(5'b10000);
        check_disp("div_zero");

        set_e(1'b0);
        press(5'b01000);
        check_disp("back_to_operands");

        // toggling E alone leaves the display untouched
        set_e(1'b1);
        repeat (3) @(posedge clk);
        check_disp("e_toggle");

        press(5'b00111);
        press(5'b10000);
        check_disp("multi_op");
        set_e(1'b0);
        press(5'b01111);
        check_disp("multi_digit");

        for (int k = 0; k < 40; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0)      set_e(~E);
            else if (r <= 2) press(5'b10000);
            else             press({1'b0, 4'($urandom_range(1, 15))});
            if (k % 4 == 3) check_disp("rand");
        end
        check_disp("final");

        $display("CHECKS %0d ERRORS %0d", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/calc.md
CALC -- requirements
Module: calc

Interface
REQ-001 Parameter REFRESH_W, default 18, SHALL set the display-scan counter width; digit select = counter[REFRESH_W-1:REFRESH_W-2].
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 A, B, C, D  input  1 each  SHALL be push buttons: digit increment (E=0) or operator select (E=1).
REQ-005 E  input  1  SHALL be a level switch: 0 = digit entry, 1 = operator select.
REQ-006 gen  input  1  SHALL be a push button that computes and displays the result.
REQ-007 LEDs  output  7  SHALL be the active-low segments of the selected digit: LEDs[0]=a … LEDs[6]=g.
REQ-008 active  output  4  SHALL be the active-low digit enables; active[3] = leftmost digit, active[0] = rightmost digit.
REQ-009 point  output  1  SHALL be the active-low decimal point of the selected digit.

Function
REQ-010 Every button input SHALL pass through a 2-flop synchronizer and a rising-edge detector; one press (any hold length of at least 1 clock) SHALL give exactly one event.
REQ-011 State: four BCD digits dA, dB, dC, dD; operand X = 10*dA + dB; operand Y = 10*dC + dD (0–99 each).
REQ-012 State: operator op in {ADD, SUB, MUL, DIV}; 14-bit result magnitude R; flags neg and err; show_result.
REQ-013 With E=0, each event on A/B/C/D SHALL increment dA/dB/dC/dD respectively, wrapping 9→0, and SHALL clear show_result.
REQ-014 With E=1, events on A/B/C/D SHALL set op to ADD/SUB/MUL/DIV respectively; digits SHALL be unchanged and the last event SHALL win.
REQ-015 Simultaneous events SHALL each take effect independently; if several operator events occur in one cycle, the priority SHALL be D > C > B > A.
REQ-016 A gen event SHALL capture X, Y and op, compute the result, and set show_result=1. The display SHALL show the new result no later than 4 clocks after gen rises at the pin.
REQ-017 ADD: R = X+Y. MUL: R = X*Y (maximum 9801).
REQ-018 SUB: if X≥Y, R = X−Y; otherwise R = Y−X and neg=1.
REQ-019 DIV: R = floor(X/Y) and the remainder SHALL be discarded; if Y=0, R=0 and err=1.
REQ-020 neg and err SHALL clear on every gen event before the new result is computed.
REQ-021 When show_result=0, the display SHALL show dA dB dC dD on active[3..0].
REQ-022 When show_result=1, the display SHALL show R as 4 decimal digits with leading zeros.
REQ-023 Scan: a free-running counter SHALL drive exactly one active bit low at a time, cycling through active[0], [1], [2], [3]. LEDs and point SHALL match the digit currently selected.
REQ-024 Segment codes (active-low, g…a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-025 point SHALL be low only in these cases: neg=1 while the leftmost digit is selected; or err=1 on any digit. These apply only while show_result=1.
REQ-026 A change of E level SHALL NOT itself alter any state.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL clear all digits, the scan counter, R, neg, err, show_result and the synchronizers, and SHALL set op=ADD.
REQ-028 Outputs in the first clock after reset: active=1110, LEDs=1000000, point=1.
REQ-029 Button events SHALL be ignored during reset. A press still held when reset releases SHALL NOT count as an event.

Verification
REQ-030 Reset, then scan all four digits: each digit shows 0 (LEDs=1000000) and point=1.
REQ-031 E=0, press each of A–D 9 times: display 9999. A 10th press on A: display 0999.
REQ-032 Digits 9999, E=1, press A, B, C, then D, then gen: op=DIV, display 0001. Same digits with op MUL: display 9801.
REQ-033 Digits 1234, op SUB, gen: display 0022, point low on the leftmost digit only. With 3412: 0022, point high.
REQ-034 Digits 4705, op DIV, gen: display 0009. Digits 4700, gen: display 0000, point low on all digits.
REQ-035 After a result, E=0 and one press of D: the display returns to the operands with dD incremented and point high.
